// File: rtl/tqvp_cattuto_vga_monitor.sv
// ---------------------------------------------------------------------------
// tqvp_cattuto_vga_monitor
//
// This block is a TinyQV peripheral that measures an incoming VGA hsync/vsync
// pair. It reports the line period and hsync pulse width in clocks. It also
// reports the lines per frame and the vsync pulse width in lines. It locks
// when two consecutive frames report the same geometry.
//
// The working counters run all the time. Their values are copied to shadow
// registers on each vsync leading edge, so a CPU read always returns a
// coherent set of values from a single frame.
//
// Optional feature: define TQVP_VGAMON_FRAMECNT_EN to build the 16-bit
// published-frame counter at word 0x03. Without it, word 0x03 reads 0.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   ui_in[1]/[2]     hsync / vsync (already synchronised)
//   uo_out           {locked, valid, 6'b0}
//   address ..       TinyQV peripheral bus; data_ready is always 1 and
//   user_interrupt   data_out is decoded combinationally from address
// ---------------------------------------------------------------------------
module tqvp_cattuto_vga_monitor #(
  parameter int CLOCK_MHZ = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEEK = 2'd1, MEASURE = 2'd2, LOCKED = 2'd3} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  ctrl_reg;
  logic        hs_prev_reg, vs_prev_reg;
  logic [15:0] hcnt_reg, pcnt_reg, hper_w_reg, hpul_w_reg;
  logic        pulse_run_reg;
  logic [11:0] lcnt_reg, vcnt_reg;
  logic [15:0] hper_s_reg, hpul_s_reg;
  logic [11:0] lines_s_reg, vpul_s_reg;
  logic        valid_reg, irq_reg;
  logic [15:0] framecnt_val;

  // The CLOCK_MHZ parameter and the unused input bits are deliberately ignored.
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[7:3], ui_in[0], data_in[31:4], (CLOCK_MHZ != 0)};

  logic wr_en, rd_status;
  assign wr_en     = (data_write_n != 2'b11);
  assign rd_status = (data_read_n != 2'b11) && (address == 6'h3F);

  // XNOR with the polarity bit maps the raw level onto "active".
  logic hs_act, vs_act, hs_edge, vs_edge;
  assign hs_act  = ui_in[1] ~^ ctrl_reg[1];
  assign vs_act  = ui_in[2] ~^ ctrl_reg[2];
  assign hs_edge = hs_act & ~(hs_prev_reg ~^ ctrl_reg[1]);
  assign vs_edge = vs_act & ~(vs_prev_reg ~^ ctrl_reg[2]);

  logic        measuring, timeout, publish, pulse_end, match;
  logic [15:0] hper_new, hper_pub, hpul_pub;
  logic [11:0] lines_pub;

  assign measuring = (state_reg == MEASURE) || (state_reg == LOCKED);
  // hcnt saturates at 0xFFFF. Using >= keeps the timeout active even if
  // the counter was already saturated when measurement started.
  assign timeout   = ctrl_reg[0] && measuring && !hs_edge && (hcnt_reg >= 16'hFFFE);
  assign publish   = ctrl_reg[0] && measuring && vs_edge && !timeout;
  assign pulse_end = pulse_run_reg && !hs_act;
  assign hper_new  = (hcnt_reg == 16'hFFFF) ? 16'hFFFF : hcnt_reg + 16'd1;

  // Include any line or pulse that ends in the publish cycle. This way the
  // hsync edge is counted before the frame is closed.
  assign hper_pub  = hs_edge ? hper_new : hper_w_reg;
  assign hpul_pub  = pulse_end ? pcnt_reg : hpul_w_reg;
  assign lines_pub = (hs_edge && lcnt_reg != 12'hFFF) ? lcnt_reg + 12'd1 : lcnt_reg;
  assign match     = (hper_pub == hper_s_reg) && (lines_pub == lines_s_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = SEEK;
      SEEK:    if (vs_edge) state_next = MEASURE;
      MEASURE: if (timeout) state_next = SEEK;
               else if (publish && match) state_next = LOCKED;
      LOCKED:  if (timeout) state_next = SEEK;
               else if (publish && !match) state_next = MEASURE;
      default: state_next = IDLE;
    endcase
    if (!ctrl_reg[0]) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ctrl_reg      <= 4'h0;
      hs_prev_reg   <= 1'b0;
      vs_prev_reg   <= 1'b0;
      hcnt_reg      <= 16'h0;
      pcnt_reg      <= 16'h0;
      hper_w_reg    <= 16'h0;
      hpul_w_reg    <= 16'h0;
      pulse_run_reg <= 1'b0;
      lcnt_reg      <= 12'h0;
      vcnt_reg      <= 12'h0;
      hper_s_reg    <= 16'h0;
      hpul_s_reg    <= 16'h0;
      lines_s_reg   <= 12'h0;
      vpul_s_reg    <= 12'h0;
      valid_reg     <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      hs_prev_reg <= ui_in[1];
      vs_prev_reg <= ui_in[2];
      if (wr_en && address == 6'h00) ctrl_reg <= data_in[3:0];

      if (publish) begin
        hper_s_reg  <= hper_pub;
        hpul_s_reg  <= hpul_pub;
        lines_s_reg <= lines_pub;
        vpul_s_reg  <= vcnt_reg;
      end

      // A new publish takes priority over a clear from a STATUS read.
      if (publish && ctrl_reg[3]) irq_reg <= 1'b1;
      else if (rd_status)         irq_reg <= 1'b0;

      if (!ctrl_reg[0]) begin
        hcnt_reg      <= 16'h0;
        pcnt_reg      <= 16'h0;
        hper_w_reg    <= 16'h0;
        hpul_w_reg    <= 16'h0;
        pulse_run_reg <= 1'b0;
        lcnt_reg      <= 12'h0;
        vcnt_reg      <= 12'h0;
        valid_reg     <= 1'b0;
      end else begin
        if (hs_edge) begin
          hcnt_reg   <= 16'h0;
          hper_w_reg <= hper_new;
        end else if (hcnt_reg != 16'hFFFF) begin
          hcnt_reg <= hcnt_reg + 16'd1;
        end

        if (hs_edge) begin
          pcnt_reg      <= 16'd1;
          pulse_run_reg <= 1'b1;
        end else if (pulse_end) begin
          hpul_w_reg    <= pcnt_reg;
          pulse_run_reg <= 1'b0;
        end else if (pulse_run_reg && pcnt_reg != 16'hFFFF) begin
          pcnt_reg <= pcnt_reg + 16'd1;
        end

        // On a vsync edge, a coincident hsync edge closes the old frame's
        // line count. It also opens the new vsync pulse.
        if (vs_edge) begin
          lcnt_reg <= 12'h0;
          vcnt_reg <= hs_edge ? 12'd1 : 12'd0;
        end else begin
          lcnt_reg <= lines_pub;
          if (vs_act && hs_edge && vcnt_reg != 12'hFFF) vcnt_reg <= vcnt_reg + 12'd1;
        end

        if (timeout)      valid_reg <= 1'b0;
        else if (publish) valid_reg <= 1'b1;
      end
    end
  end

`ifdef TQVP_VGAMON_FRAMECNT_EN
  logic [15:0] framecnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       framecnt_reg <= 16'h0;
    else if (publish) framecnt_reg <= framecnt_reg + 16'd1;
  end
  assign framecnt_val = framecnt_reg;
`else
  assign framecnt_val = 16'h0;
`endif

  logic locked;
  assign locked         = (state_reg == LOCKED);
  assign uo_out         = {locked, valid_reg, 6'b0};
  assign user_interrupt = irq_reg;
  assign data_ready     = 1'b1;

  always_comb begin
    data_out = 32'h0;
    case (address)
      6'h00:   data_out = {28'h0, ctrl_reg};
      6'h01:   data_out = {hpul_s_reg, hper_s_reg};
      6'h02:   data_out = {4'h0, vpul_s_reg, 4'h0, lines_s_reg};
      6'h03:   data_out = {16'h0, framecnt_val};
      6'h3F:   data_out = {25'h0, 1'b0, state_reg, 1'b0, irq_reg, locked, valid_reg};
      default: data_out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_tqvp_cattuto_vga_monitor.sv
// ---------------------------------------------------------------------------
// Directed testbench for tqvp_cattuto_vga_monitor.
//
// The bench uses shortened video timing so that each frame is short:
//   line = 32 clocks, hsync pulse = 4 clocks, 10 lines per frame,
//   vsync pulse = 2 lines.
// The timeout and saturation cases use their real lengths.
// The bench drives the inputs and samples the outputs 1 ns after the rising
// clock edge.
// ---------------------------------------------------------------------------
module tb_tqvp_cattuto_vga_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h06;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h0;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  // Timing of the generated frames and the active level of each sync.
  int g_period = 32, g_pulse = 4, g_lines = 10, g_vlines = 2;
  bit g_hpol = 1'b0, g_vpol = 1'b0;

  localparam logic [31:0] EXP_H = 32'h0004_0020;  // HPULSE=4, HPERIOD=32
  localparam logic [31:0] EXP_V = 32'h0002_000A;  // VPULSE=2, LINES=10

  tqvp_cattuto_vga_monitor dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one clock of a frame. The index counts clocks from the frame start.
  task automatic drive_cycle(input int idx);
    int l, c;
    l = idx / g_period;
    c = idx % g_period;
    ui_in[1] = (c < g_pulse)  ? g_hpol : !g_hpol;
    ui_in[2] = (l < g_vlines) ? g_vpol : !g_vpol;
    tick();
  endtask

  task automatic frame_cycles(input int from, input int to);
    for (int i = from; i < to; i++) drive_cycle(i);
  endtask

  task automatic frame();
    frame_cycles(0, g_period * g_lines);
  endtask

  task automatic idle(input int n);
    ui_in[1] = !g_hpol;
    ui_in[2] = !g_vpol;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    address = 6'h0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    ui_in = 8'h0;
    idle(3);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, data_out, exp);
  endtask

  initial begin
    // ---- Reset state ----
    do_reset();
    rd("rst_ctrl", 6'h00, 32'h0);
    rd("rst_h", 6'h01, 32'h0);
    rd("rst_v", 6'h02, 32'h0);
    rd("rst_fc", 6'h03, 32'h0);
    rd("rst_status", 6'h3F, 32'h0);
    check("rst_uo", uo_out, 8'h00);
    check("rst_irq", user_interrupt, 1'b0);
    check("data_ready", data_ready, 1'b1);

    // ---- Nominal timing, active-low syncs ----
    wr(6'h00, 32'h1);
    idle(2);
    rd("seek_state", 6'h3F, 32'h10);
    frame();                 // vsync edge 1: SEEK -> MEASURE
    frame();                 // vsync edge 2: first publish
    rd("nom_h", 6'h01, EXP_H);
    rd("nom_v", 6'h02, EXP_V);
    rd("nom_status", 6'h3F, 32'h21);
    check("nom_uo", uo_out, 8'h40);
    frame();                 // vsync edge 3: same geometry -> LOCKED
    rd("lock_status", 6'h3F, 32'h33);
    check("lock_uo", uo_out, 8'hC0);
    frame_cycles(0, 1);      // vsync edge 4: third publish
`ifdef TQVP_VGAMON_FRAMECNT_EN
    rd("framecnt", 6'h03, 32'h3);
`else
    rd("framecnt_off", 6'h03, 32'h0);
`endif
    rd("still_locked", 6'h3F, 32'h33);
    rd("ctrl_rb", 6'h00, 32'h1);
    wr(6'h01, 32'hFFFF_FFFF);  // write to a read-only register: ignored
    rd("ro_write", 6'h01, EXP_H);
    // Disable while LOCKED: the block goes to IDLE and keeps its shadows.
    wr(6'h00, 32'h0);
    tick();
    rd("dis_status", 6'h3F, 32'h0);
    check("dis_uo", uo_out, 8'h00);
    rd("dis_keep_h", 6'h01, EXP_H);

    // ---- Interrupt path ----
    do_reset();
    wr(6'h00, 32'h9);
    idle(2);
    frame();
    frame_cycles(0, 1);      // vsync edge 2: publish sets irq
    check("irq_set", user_interrupt, 1'b1);
    data_read_n = 2'b00;
    rd("irq_status", 6'h3F, 32'h25);
    frame_cycles(1, 2);
    data_read_n = 2'b11;
    check("irq_clr", user_interrupt, 1'b0);
    frame_cycles(2, g_period * g_lines);
    address = 6'h3F;
    data_read_n = 2'b00;     // STATUS read in the same cycle as publish 3
    frame_cycles(0, 1);
    data_read_n = 2'b11;
    check("irq_set_wins", user_interrupt, 1'b1);
    frame_cycles(1, 20);
    check("pre_rst_uo", uo_out, 8'hC0);
    // Assert reset in the middle of a line, between clock edges.
    #1 rst_n = 1'b0;
    #1;
    check("arst_uo", uo_out, 8'h00);
    check("arst_irq", user_interrupt, 1'b0);
    rd("arst_ctrl", 6'h00, 32'h0);
    rd("arst_h", 6'h01, 32'h0);
    rd("arst_v", 6'h02, 32'h0);
    rd("arst_status", 6'h3F, 32'h0);
    rst_n = 1'b1;
    tick();
    rd("resume_idle", 6'h3F, 32'h0);

    // ---- Inverted (active-high) syncs give identical measurements ----
    g_hpol = 1'b1;
    g_vpol = 1'b1;
    do_reset();
    wr(6'h00, 32'h7);
    idle(2);
    frame();
    frame();
    rd("pol_h", 6'h01, EXP_H);
    rd("pol_v", 6'h02, EXP_V);
    frame();
    rd("pol_lock", 6'h3F, 32'h33);
    g_hpol = 1'b0;
    g_vpol = 1'b0;

    // ---- LINES saturation: 5000 two-clock lines in one frame ----
    do_reset();
    wr(6'h00, 32'h1);
    idle(2);
    g_period = 2; g_pulse = 1; g_lines = 5000; g_vlines = 1;
    frame();                 // vsync edge 1 at the start of the long frame
    frame_cycles(0, 1);      // vsync edge 2 publishes it
    rd("sat_v", 6'h02, 32'h0001_0FFF);
    rd("sat_h", 6'h01, 32'h0001_0002);
    rd("sat_status", 6'h3F, 32'h21);
    g_period = 32; g_pulse = 4; g_lines = 10; g_vlines = 2;

    // ---- Timeout while LOCKED ----
    do_reset();
    wr(6'h00, 32'h1);
    idle(2);
    frame();
    frame();
    frame();
    rd("to_locked", 6'h3F, 32'h33);
    idle(60000);
    rd("to_not_yet", 6'h3F, 32'h33);
    idle(5600);
    rd("to_status", 6'h3F, 32'h10);
    check("to_uo", uo_out, 8'h00);
    rd("to_keep_h", 6'h01, EXP_H);
    rd("to_keep_v", 6'h02, EXP_V);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tqvp_cattuto_vga_monitor.md
TQVP_CATTUTO_VGA_MONITOR -- requirements
Module: tqvp_cattuto_vga_monitor

Interface
REQ-001 SHALL have parameter CLOCK_MHZ, default 64, nominal clk frequency in MHz (informational only, no effect on logic).
REQ-002 SHALL have port clk, input, 1, TinyQV project clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ui_in, input, 8, synchronized PMOD inputs: ui_in[1] = hsync, ui_in[2] = vsync, other bits unused.
REQ-005 SHALL have port uo_out, output, 8: [7] = locked, [6] = valid, [5:0] = 0.
REQ-006 SHALL have ports address (input, 6), data_in (input, 32), data_write_n (input, 2), data_read_n (input, 2), data_out (output, 32), data_ready (output, 1), user_interrupt (output, 1), using standard TinyQV peripheral semantics.

Function
REQ-007 SHALL measure an incoming VGA sync pair: it is the receiving end of the TinyVGA sync interface.
REQ-008 SHALL detect leading edges by comparing each sync input with its value one cycle earlier.
- Leading edge = transition into the active level.
- Active level = high when the polarity bit is 1, low when it is 0.
- An edge is acted on in the cycle after the input changes.
REQ-009 SHALL define HPERIOD = N when consecutive hsync leading edges are N cycles apart; 16-bit.
REQ-010 SHALL define HPULSE = number of cycles hsync stays active after its leading edge; 16-bit.
REQ-011 SHALL define LINES = number of hsync leading edges between consecutive vsync leading edges; 12-bit, saturating at 0xFFF.
REQ-012 SHALL define VPULSE = number of hsync leading edges while vsync is active; 12-bit, saturating at 0xFFF.
REQ-013 SHALL accumulate HPERIOD/HPULSE from the most recent complete line and LINES/VPULSE in working counters.
REQ-014 SHALL copy all working values to the readable shadow registers in the single cycle a vsync leading edge is acted on, so reads are always frame-coherent.
REQ-015 SHALL implement FSM states IDLE=0, SEEK=1, MEASURE=2, LOCKED=3.
- IDLE -> SEEK when CTRL.en=1.
- SEEK -> MEASURE on a vsync leading edge; the shadow registers are not published on this transition.
- MEASURE: publish on each vsync leading edge; set valid=1; go to LOCKED if the published HPERIOD and LINES equal the previous published values.
- LOCKED -> MEASURE on any mismatch at publish.
REQ-016 SHALL treat a timeout as follows.
- Trigger: no hsync leading edge for 65535 consecutive cycles.
- Applies in MEASURE or LOCKED.
- Action: go to SEEK and clear valid and locked.
REQ-017 SHALL go to IDLE from any state within one cycle of CTRL.en=0, clearing working counters, valid and locked; shadow values are retained.
REQ-018 SHALL give an hsync edge and a vsync edge in the same cycle this order: count the line first, then publish.
REQ-019 SHALL use this register map (word index):
- 0x00 CTRL, rw, [0] en, [1] hsync active-high, [2] vsync active-high, [3] irq enable.
- 0x01 HPERIOD[15:0] and HPULSE[31:16], ro.
- 0x02 LINES[11:0] and VPULSE[27:16], ro.
- 0x03 FRAMECNT[15:0], ro.
- 0x3F STATUS, ro: {25'b0, state[6:4], 1'b0, irq[2], locked[1], valid[0]}.
- Any other address reads 0; writes to read-only registers are ignored.
REQ-020 SHALL accept writes of any width, using data_in[3:0] for CTRL.
REQ-021 SHALL keep data_ready constantly 1 and drive data_out combinationally from address.
REQ-022 SHALL set the irq flag on every publish when CTRL[3]=1.
- user_interrupt = irq flag.
- A read of STATUS clears the flag, unless a new publish occurs in the same cycle; the set wins.
REQ-023 SHALL increment FRAMECNT by 1 on each publish, wrapping from 0xFFFF to 0.

Reset
REQ-024 SHALL, while rst_n=0, immediately force to 0: CTRL, all counters, shadows, FRAMECNT, valid, locked, irq; state = IDLE.
REQ-025 SHALL therefore drive uo_out=0 and user_interrupt=0 during reset, including reset asserted mid-frame.
REQ-026 SHALL resume in IDLE on the first clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL implement FRAMECNT and its increment logic only when macro TQVP_VGAMON_FRAMECNT_EN is defined.
REQ-028 SHALL, without TQVP_VGAMON_FRAMECNT_EN, omit the counter and return 0 for address 0x03; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover nominal timing with CTRL=0x1 and 1024x768 timing: line 1344 cycles, 136-cycle low hsync, 806 lines, 6-line low vsync.
- After 2nd vsync edge: HPERIOD=1344, HPULSE=136, LINES=806, VPULSE=6, valid=1, state=2.
- After 3rd vsync edge: locked=1, state=3, uo_out=0xC0.
REQ-030 SHALL cover the interrupt path: CTRL=0x9, same stimulus.
- user_interrupt=1 the cycle after a publish.
- A STATUS read returns bit2=1 and clears user_interrupt next cycle.
- A STATUS read coinciding with a publish leaves it set.
REQ-031 SHALL cover timeout: hold hsync inactive 65535 cycles while LOCKED -> valid=0, locked=0, state=1; shadows unchanged.
REQ-032 SHALL cover polarity and saturation:
- CTRL=0x7 with inverted syncs -> identical measurements.
- 5000 lines per frame -> LINES=0xFFF.
REQ-033 SHALL cover reset and disable:
- rst_n low mid-line -> all reads 0 and uo_out=0 without a clock edge.
- CTRL=0 while LOCKED -> state=0 next cycle.
REQ-034 SHALL cover the macro: with TQVP_VGAMON_FRAMECNT_EN, 3 publishes -> FRAMECNT=3; without it, address 0x03 reads 0.
